// File: rtl/systolic_mac_array.sv
// systolic_mac_array: ROWS x COLS systolic outer-product MAC array with a valid/ready result register.
// Optional SYSTOLIC_SAT_EN: accumulators saturate at 2^AW-1 instead of wrapping.
module systolic_mac_array #(
    parameter int DW   = 8,
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int AW   = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [ROWS*DW-1:0]        x_vec,
    input  logic [COLS*DW-1:0]        y_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROWS*COLS*AW-1:0]   acc_flat,
    output logic                      busy
);
    localparam int CW = $clog2(ROWS + COLS);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic take, tag_v, tag_f, cap;
    logic [DW-1:0] xt [ROWS][COLS];
    logic [DW-1:0] yt [ROWS][COLS];
    logic vt [ROWS][COLS];
    logic ft [ROWS][COLS];
    assign take      = in_valid && in_ready;
    assign tag_v     = take && (state == ACCUM || in_first);
    assign tag_f     = tag_v && in_first;
    assign in_ready  = rst && (state == IDLE || state == ACCUM);
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;
    always_comb begin
        state_nx = state;
        cap = 1'b0;
        case (state)
            IDLE:  if (take && in_first) state_nx = in_last ? DRAIN : ACCUM;
            ACCUM: if (take && in_last) state_nx = DRAIN;
            DRAIN: if (cnt == CW'(ROWS + COLS - 1)) begin
                cap = 1'b1;
                state_nx = HOLD;
            end
            HOLD:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= (state == DRAIN) ? cnt + 1'b1 : '0;
        end
    end
    // Row i delays x by i, then each further tap is one PE to the right.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        logic [DW+1:0] xs [i+COLS];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < i + COLS; k++) xs[k] <= '0;
            end else begin
                xs[0] <= {tag_v, tag_f, x_vec[i*DW +: DW]};
                for (int k = 1; k < i + COLS; k++) xs[k] <= xs[k-1];
            end
        end
        for (genvar j = 0; j < COLS; j++) begin : g_tap
            assign {vt[i][j], ft[i][j], xt[i][j]} = xs[i+j];
        end
    end
    for (genvar j = 0; j < COLS; j++) begin : g_col
        logic [DW-1:0] ys [j+ROWS];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < j + ROWS; k++) ys[k] <= '0;
            end else begin
                ys[0] <= y_vec[j*DW +: DW];
                for (int k = 1; k < j + ROWS; k++) ys[k] <= ys[k-1];
            end
        end
        for (genvar i = 0; i < ROWS; i++) begin : g_tap
            assign yt[i][j] = ys[i+j];
        end
    end
    for (genvar i = 0; i < ROWS; i++) begin : g_pe_r
        for (genvar j = 0; j < COLS; j++) begin : g_pe_c
            logic [2*DW-1:0] p;
            logic [AW-1:0] acc, res, nxt;
            assign p = xt[i][j] * yt[i][j];
`ifdef SYSTOLIC_SAT_EN
            logic [AW:0] sum;
            assign sum = {1'b0, acc} + (AW+1)'(p);
            assign nxt = sum[AW] ? '1 : sum[AW-1:0];
`else
            assign nxt = acc + AW'(p);
`endif
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc <= '0;
                    res <= '0;
                end else begin
                    if (vt[i][j]) acc <= ft[i][j] ? AW'(p) : nxt;
                    if (cap) res <= acc;
                end
            end
            assign acc_flat[(i + j*ROWS)*AW +: AW] = res;
        end
    end
endmodule

// File: tb/tb_systolic_mac_array.sv
// tb_systolic_mac_array: randomized scoreboard bench for systolic_mac_array.
// Expected matrices come from a plain-arithmetic model of the beat stream.
module tb_systolic_mac_array;
    localparam int DW = 8, ROWS = 2, COLS = 2, AW = 20;
    localparam int MW = ROWS*COLS*AW;
    logic clk = 0, rst, in_valid, in_ready, in_first, in_last, out_valid, out_ready, busy;
    logic [ROWS*DW-1:0] x_vec;
    logic [COLS*DW-1:0] y_vec;
    logic [MW-1:0] acc_flat;
    int checks = 0, errors = 0, cyc = 0;
    bit rand_ready = 0, active = 0, pv = 0;
    logic [MW-1:0] exp_q [$];
    int lat_q [$];
    longint sm [ROWS][COLS];

    systolic_mac_array #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .x_vec(x_vec), .y_vec(y_vec),
        .out_valid(out_valid), .out_ready(out_ready), .acc_flat(acc_flat), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_beat(input logic [ROWS*DW-1:0] x, input logic [COLS*DW-1:0] y, input bit f, input bit l);
        logic [MW-1:0] e;
        longint mx;
        mx = (longint'(1) << AW) - 1;
        if (!active && !f) return;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                longint p;
                p = longint'(x[i*DW +: DW]) * longint'(y[j*DW +: DW]);
                sm[i][j] = f ? p : sm[i][j] + p;
            end
        active = !l;
        if (l) begin
            e = '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
`ifdef SYSTOLIC_SAT_EN
                    e[(i + j*ROWS)*AW +: AW] = AW'(sm[i][j] > mx ? mx : sm[i][j]);
`else
                    e[(i + j*ROWS)*AW +: AW] = AW'(sm[i][j] & mx);
`endif
            exp_q.push_back(e);
            lat_q.push_back(cyc + 1);
        end
    endtask

    task automatic send(input logic [ROWS*DW-1:0] x, input logic [COLS*DW-1:0] y, input bit f, input bit l);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("in_ready_wait", MW'(in_ready), MW'(1));
        if (!in_ready) return;
        in_valid = 1;
        x_vec = x;
        y_vec = y;
        in_first = f;
        in_last = l;
        model_beat(x, y, f, l);
        tick();
        in_valid = 0;
        in_first = 0;
        in_last = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", MW'(exp_q.size()), MW'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && !pv) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 want no pending job");
                end else chk("latency", MW'(cyc - lat_q.pop_front()), MW'(ROWS + COLS));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h want none", acc_flat);
                end else chk("result", acc_flat, exp_q.pop_front());
            end
            pv = out_valid;
        end
    end

    initial begin
        logic [MW-1:0] c;
        int n;
        rst = 0; in_valid = 0; in_first = 0; in_last = 0; out_ready = 0;
        x_vec = '0; y_vec = '0;
        #1;
        chk("rst_out_valid", MW'(out_valid), MW'(0));
        chk("rst_busy", MW'(busy), MW'(0));
        chk("rst_in_ready", MW'(in_ready), MW'(0));
        chk("rst_acc", acc_flat, '0);
        tick(); tick();
        rst = 1;
        #1;
        chk("rel_in_ready", MW'(in_ready), MW'(1));
        // single-beat job
        out_ready = 1;
        send({8'd2, 8'd8}, {8'd3, 8'd4}, 1, 1);
        drain();
        c = {20'd6, 20'd24, 20'd8, 20'd32};
        chk("k1_acc", acc_flat, c);
        // three beats with a bubble
        send({8'd2, 8'd1}, {8'd4, 8'd3}, 1, 0);
        tick();
        send({8'd6, 8'd5}, {8'd8, 8'd7}, 0, 0);
        send({8'd0, 8'd10}, {8'd2, 8'd1}, 0, 1);
        drain();
        chk("k3_acc", acc_flat, {20'd56, 20'd64, 20'd48, 20'd48});
        // output backpressure
        out_ready = 0;
        send({8'd2, 8'd8}, {8'd3, 8'd4}, 1, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_valid_rise", MW'(out_valid), MW'(1));
        repeat (5) begin
            tick();
            chk("bp_valid", MW'(out_valid), MW'(1));
            chk("bp_acc", acc_flat, c);
            chk("bp_in_ready", MW'(in_ready), MW'(0));
        end
        out_ready = 1;
        tick();
        chk("hs_valid_drop", MW'(out_valid), MW'(0));
        chk("hs_in_ready", MW'(in_ready), MW'(1));
        // overflow behaviour
        for (int k = 0; k < 20; k++) send('1, '1, k == 0, k == 19);
        drain();
`ifdef SYSTOLIC_SAT_EN
        chk("ovf_acc", acc_flat, {4{20'd1048575}});
`else
        chk("ovf_acc", acc_flat, {4{20'd251924}});
`endif
        // reset in the middle of a job
        send({8'd7, 8'd7}, {8'd7, 8'd7}, 1, 0);
        send({8'd7, 8'd7}, {8'd7, 8'd7}, 0, 0);
        rst = 0;
        active = 0;
        #1;
        chk("mid_rst_valid", MW'(out_valid), MW'(0));
        chk("mid_rst_acc", acc_flat, '0);
        chk("mid_rst_busy", MW'(busy), MW'(0));
        tick(); tick();
        rst = 1;
        #1;
        chk("mid_rel_in_ready", MW'(in_ready), MW'(1));
        send({8'd255, 8'd255}, {8'd1, 8'd1}, 1, 1);
        drain();
        chk("post_rst_acc", acc_flat, {4{20'd255}});
        // restart inside ACCUM
        send({8'd9, 8'd9}, {8'd9, 8'd9}, 1, 0);
        send({8'd1, 8'd1}, {8'd3, 8'd2}, 1, 1);
        drain();
        chk("restart_acc", acc_flat, {20'd3, 20'd3, 20'd2, 20'd2});
        // random jobs with stray beats, restarts, bubbles and random backpressure
        rand_ready = 1;
        for (int jb = 0; jb < 40; jb++) begin
            int kk;
            if ($urandom_range(0, 4) == 0)
                send((ROWS*DW)'($urandom()), (COLS*DW)'($urandom()), 0, $urandom_range(0, 1) == 1);
            kk = $urandom_range(1, 6);
            for (int k = 0; k < kk; k++) begin
                send((ROWS*DW)'($urandom()), (COLS*DW)'($urandom()),
                     k == 0 || $urandom_range(0, 9) == 0, k == kk - 1);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        rand_ready = 0;
        out_ready = 1;
        drain();
        chk("lat_q_empty", MW'(lat_q.size()), MW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
